// File: rtl/hazard_scoreboard.sv
// Register-hazard scoreboard: one latency counter per architectural register,
// stalling decode on RAW (and optionally WAW) against results still in flight.
module hazard_scoreboard #(
  parameter int REG_W     = 5,
  parameter int LAT_W     = 3,
  parameter bit WAW_CHECK = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  id_valid_i,
  input  logic [4:0]            opcode_i,
  input  logic [2:0]            funct3_i,
  input  logic [REG_W-1:0]      rs1_i,
  input  logic [REG_W-1:0]      rs2_i,
  input  logic [REG_W-1:0]      rd_i,
  input  logic                  rd_we_i,
  input  logic [LAT_W-1:0]      lat_i,
  input  logic                  flush_i,
  input  logic                  wb_valid_i,
  input  logic [REG_W-1:0]      wb_rd_i,
  output logic                  stall_o,
  output logic [2**REG_W-1:0]   pending_o,
  output logic                  busy_o
);

  localparam int NUM_REGS = 2**REG_W;
  localparam logic [LAT_W-1:0] VAR = '1;

  function automatic logic uses_rs1(input logic [4:0] op, input logic [2:0] f3);
    logic u;
    case (op)
      5'b11000, 5'b11001, 5'b00000, 5'b01000, 5'b00100, 5'b01100: u = 1'b1;
      5'b11100: u = (f3 != 3'd0) && !f3[2];
      default:  u = 1'b0;
    endcase
    return u;
  endfunction

  function automatic logic uses_rs2(input logic [4:0] op);
    return (op == 5'b11000) || (op == 5'b01000) || (op == 5'b01100);
  endfunction

  logic [LAT_W-1:0]    cnt_q [NUM_REGS];
  logic [LAT_W-1:0]    cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;
  logic                raw;
  logic                waw;
  logic                stall;
  logic                issue;
  logic                load_en;

  // Hazard detection against the current counter state (x0 is never pending).
  always_comb begin
    raw = (uses_rs1(opcode_i, funct3_i) && (cnt_q[rs1_i] != '0)) ||
          (uses_rs2(opcode_i)           && (cnt_q[rs2_i] != '0));
    waw = WAW_CHECK && rd_we_i && (rd_i != '0) && (cnt_q[rd_i] != '0);
    stall   = id_valid_i && !flush_i && reset_i && (raw || waw);
    issue   = id_valid_i && !stall && !flush_i;
    load_en = issue && rd_we_i && (rd_i != '0) && (lat_i != '0);
  end

  assign stall_o = stall;

  // Next counter state: countdown / writeback clear, then issue load wins, flush clears all.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (cnt_q[r] != '0 && cnt_q[r] != VAR) begin
        cnt_d[r] = cnt_q[r] - 1'b1;
      end else if (cnt_q[r] == VAR && wb_valid_i && wb_rd_i == REG_W'(r)) begin
        cnt_d[r] = '0;
      end
      if (load_en && rd_i == REG_W'(r)) begin
        cnt_d[r] = lat_i;
      end
      if (flush_i || r == 0) begin
        cnt_d[r] = '0;
      end
      pending_d[r] = (cnt_d[r] != '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
      pending_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;
  assign busy_o    = |pending_q;

endmodule
